game_sequencer: RTL and testbench

//  Central game controller for the dinosaur runner. Sequences the Jump, Ground and Cactus blocks.

---
 rtl/dino_pkg.sv | 16 +
 rtl/bcd4_sat_inc.sv | 29 ++
 rtl/game_sequencer.sv | 136 +++++++++++++
 tb/tb_game_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared types and constants for the dinosaur runner game controller.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  typedef logic [15:0] bcd4_t;

  localparam bcd4_t BCD_MAX = 16'h9999;
  localparam int    SPEED_W = 4;

endpackage

// File: rtl/bcd4_sat_inc.sv
// Combinational 4-digit BCD +1 that holds at 9999 instead of wrapping.
module bcd4_sat_inc
  import dino_pkg::*;
(
  input  bcd4_t value,
  output bcd4_t result
);

  logic carry;

  always_comb begin
    result = value;
    carry  = 1'b1;
    if (value != BCD_MAX) begin
      // Ripple the +1 from the least significant digit until a digit absorbs it.
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (value[i*4 +: 4] == 4'd9) begin
            result[i*4 +: 4] = 4'd0;
          end else begin
            result[i*4 +: 4] = value[i*4 +: 4] + 4'd1;
            carry            = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Run-state controller for the dinosaur runner: arming, frame-aligned start, speed ramp, BCD score.
// Define GAME_SEQ_HISCORE_EN to build the best-score register; otherwise hiscore is tied to zero.
module game_sequencer
  import dino_pkg::*;
#(
  parameter logic [SPEED_W-1:0] INIT_SPEED        = 4'd1,
  parameter logic [SPEED_W-1:0] MAX_SPEED         = 4'd15,
  parameter int                 SPEED_STEP_FRAMES = 600,
  parameter int                 SCORE_DIV         = 6,
  parameter int                 OVER_HOLD_FRAMES  = 30
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic               vs,
  input  logic               hit,
  output logic               game_status,
  output logic               game_over,
  output logic [SPEED_W-1:0] speed,
  output bcd4_t              score,
  output bcd4_t              hiscore,
  output logic               frame_tick
);

  localparam int SC_W = $clog2(SCORE_DIV + 1);
  localparam int SP_W = $clog2(SPEED_STEP_FRAMES + 1);
  localparam int HD_W = $clog2(OVER_HOLD_FRAMES + 1);

  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCORE_DIV - 1);
  localparam logic [SP_W-1:0] SP_LAST = SP_W'(SPEED_STEP_FRAMES - 1);
  localparam logic [HD_W-1:0] HD_DONE = HD_W'(OVER_HOLD_FRAMES);

  game_state_t     state;
  logic            vs_q;
  logic            start_q;
  logic            start_rise;
  logic [SC_W-1:0] score_cnt;
  logic [SP_W-1:0] speed_cnt;
  logic [HD_W-1:0] hold_cnt;
  bcd4_t           score_inc;

  assign start_rise = start & ~start_q;

  bcd4_sat_inc u_score_inc (
    .value  (score),
    .result (score_inc)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      vs_q        <= 1'b0;
      start_q     <= 1'b0;
      frame_tick  <= 1'b0;
      game_status <= 1'b0;
      game_over   <= 1'b0;
      speed       <= INIT_SPEED;
      score       <= '0;
      score_cnt   <= '0;
      speed_cnt   <= '0;
      hold_cnt    <= '0;
    end else begin
      vs_q       <= vs;
      start_q    <= start;
      frame_tick <= vs_q & ~vs;

      case (state)
        IDLE: begin
          if (start_rise) state <= ARMED;
        end

        // Play only begins on a frame boundary so the first RUN frame is a whole frame.
        ARMED: begin
          if (frame_tick) begin
            state       <= RUN;
            game_status <= 1'b1;
            score       <= '0;
            speed       <= INIT_SPEED;
            score_cnt   <= '0;
            speed_cnt   <= '0;
          end
        end

        // A collision takes priority over the frame bookkeeping of the same cycle.
        RUN: begin
          if (hit) begin
            state       <= OVER;
            game_status <= 1'b0;
            game_over   <= 1'b1;
            hold_cnt    <= '0;
          end else if (frame_tick) begin
            if (score_cnt == SC_LAST) begin
              score_cnt <= '0;
              score     <= score_inc;
            end else begin
              score_cnt <= score_cnt + 1'b1;
            end
            if (speed_cnt == SP_LAST) begin
              speed_cnt <= '0;
              if (speed != MAX_SPEED) speed <= speed + 1'b1;
            end else begin
              speed_cnt <= speed_cnt + 1'b1;
            end
          end
        end

        OVER: begin
          if (hold_cnt == HD_DONE) begin
            if (start_rise) begin
              state     <= ARMED;
              game_over <= 1'b0;
            end
          end else if (frame_tick) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef GAME_SEQ_HISCORE_EN
  // BCD digits order the same as binary, so a plain unsigned compare is enough.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hiscore <= '0;
    end else if (state == RUN && hit && score > hiscore) begin
      hiscore <= score;
    end
  end
`else
  assign hiscore = '0;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: one default instance and one fast-ramp instance.
module tb_game_sequencer;
  import dino_pkg::*;

`ifdef GAME_SEQ_HISCORE_EN
  localparam bit HI_ON = 1'b1;
`else
  localparam bit HI_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start [2];
  logic        vs [2];
  logic        hit [2];
  logic        gs [2];
  logic        go [2];
  logic        ft [2];
  logic [3:0]  speed [2];
  bcd4_t       score [2];
  bcd4_t       hiscore [2];

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q [$];

  game_sequencer dut_a (
    .CLK(clk), .RESET(reset), .start(start[0]), .vs(vs[0]), .hit(hit[0]),
    .game_status(gs[0]), .game_over(go[0]), .speed(speed[0]),
    .score(score[0]), .hiscore(hiscore[0]), .frame_tick(ft[0])
  );

  game_sequencer #(.SPEED_STEP_FRAMES(2), .SCORE_DIV(1), .OVER_HOLD_FRAMES(2)) dut_b (
    .CLK(clk), .RESET(reset), .start(start[1]), .vs(vs[1]), .hit(hit[1]),
    .game_status(gs[1]), .game_over(go[1]), .speed(speed[1]),
    .score(score[1]), .hiscore(hiscore[1]), .frame_tick(ft[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    int v;
    v = (n > 9999) ? 9999 : n;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic frames(input int u, input int n);
    repeat (n) begin
      @(negedge clk) vs[u] = 1'b0;
      @(negedge clk) vs[u] = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic press(input int u);
    @(negedge clk) start[u] = 1'b1;
    @(negedge clk) start[u] = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_over(input int u);
    for (int i = 0; i < 8 && go[u] !== 1'b1; i++) @(negedge clk);
    check("game_over_seen", 32'(go[u]), 32'd1);
    if (exp_q.size() > 0) begin
      check("final_score", 32'(score[u]), 32'(exp_q.pop_front()));
    end else begin
      tests++;
      fails++;
      $display("FAIL score_queue: observed empty expected entry");
    end
  endtask

  task automatic end_game(input int u, input logic [15:0] exp_score);
    exp_q.push_back(exp_score);
    @(negedge clk) hit[u] = 1'b1;
    @(negedge clk) hit[u] = 1'b0;
    wait_over(u);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0; vs[u] = 1'b1; hit[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset values
    check("rst_state_a", 32'(dut_a.state), 32'(IDLE));
    check("rst_state_b", 32'(dut_b.state), 32'(IDLE));
    for (int u = 0; u < 2; u++) begin
      check("rst_status", 32'(gs[u]), 32'd0);
      check("rst_over", 32'(go[u]), 32'd0);
      check("rst_speed", 32'(speed[u]), 32'd1);
      check("rst_score", 32'(score[u]), 32'd0);
      check("rst_hiscore", 32'(hiscore[u]), 32'd0);
      check("rst_tick", 32'(ft[u]), 32'd0);
    end

    // Arm, then RUN two clocks after the vs falling edge
    press(0);
    check("armed_a", 32'(dut_a.state), 32'(ARMED));
    @(negedge clk) vs[0] = 1'b0;
    @(negedge clk);
    check("tick_lat", 32'(ft[0]), 32'd1);
    check("status_early", 32'(gs[0]), 32'd0);
    vs[0] = 1'b1;
    @(negedge clk);
    check("status_run", 32'(gs[0]), 32'd1);
    check("state_run_a", 32'(dut_a.state), 32'(RUN));

    // Score divider on the default instance
    frames(0, 59);
    check("score_59", 32'(score[0]), 32'h0009);
    frames(0, 1);
    check("score_60", 32'(score[0]), 32'h0010);
    check("speed_60", 32'(speed[0]), 32'd1);
    frames(0, 5);
    check("score_65", 32'(score[0]), 32'h0010);

    // Hit on the same clock as a frame tick that would have bumped the score
    @(negedge clk) vs[0] = 1'b0;
    @(negedge clk) begin vs[0] = 1'b1; hit[0] = 1'b1; end
    exp_q.push_back(16'h0010);
    @(negedge clk) begin hit[0] = 1'b0; start[0] = 1'b1; end
    wait_over(0);
    check("state_over_a", 32'(dut_a.state), 32'(OVER));
    check("status_over", 32'(gs[0]), 32'd0);
    check("hiscore_a", 32'(hiscore[0]), HI_ON ? 32'h0010 : 32'h0);

    // Hold period and held-start behaviour
    frames(0, 10);
    check("held_no_restart", 32'(dut_a.state), 32'(OVER));
    @(negedge clk) start[0] = 1'b0;
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk);
    check("early_press", 32'(dut_a.state), 32'(OVER));
    frames(0, 25);
    check("held_past_hold", 32'(dut_a.state), 32'(OVER));
    check("score_frozen", 32'(score[0]), 32'h0010);
    @(negedge clk) start[0] = 1'b0;
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    check("rearm", 32'(dut_a.state), 32'(ARMED));
    check("rearm_over", 32'(go[0]), 32'd0);

    // ARMED ignores hit and extra presses, then RUN entry clears the score
    @(negedge clk) hit[0] = 1'b1;
    @(negedge clk) hit[0] = 1'b0;
    check("armed_hit", 32'(dut_a.state), 32'(ARMED));
    press(0);
    check("armed_press", 32'(dut_a.state), 32'(ARMED));
    frames(0, 1);
    check("rerun", 32'(dut_a.state), 32'(RUN));
    check("rerun_score", 32'(score[0]), 32'd0);
    check("rerun_speed", 32'(speed[0]), 32'd1);

    // Fast instance: speed ramp and score per frame
    press(1);
    frames(1, 1);
    check("state_run_b", 32'(dut_b.state), 32'(RUN));
    for (int f = 1; f <= 40; f++) begin
      frames(1, 1);
      check("speed_ramp", 32'(speed[1]), (1 + f / 2 > 15) ? 32'd15 : 32'(1 + f / 2));
      check("score_ramp", 32'(score[1]), 32'(to_bcd(f)));
    end
    frames(1, 80);
    end_game(1, 16'h0120);
    check("hiscore_g1", 32'(hiscore[1]), HI_ON ? 32'h0120 : 32'h0);

    frames(1, 2);
    press(1);
    frames(1, 1);
    check("g2_speed", 32'(speed[1]), 32'd1);
    check("g2_score", 32'(score[1]), 32'd0);
    frames(1, 50);
    end_game(1, 16'h0050);
    check("hiscore_g2", 32'(hiscore[1]), HI_ON ? 32'h0120 : 32'h0);

    // Reset in the middle of a run
    frames(1, 2);
    press(1);
    frames(1, 43);
    check("score_42", 32'(score[1]), 32'h0042);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("mid_rst_state", 32'(dut_b.state), 32'(IDLE));
    check("mid_rst_score", 32'(score[1]), 32'd0);
    check("mid_rst_speed", 32'(speed[1]), 32'd1);
    check("mid_rst_status", 32'(gs[1]), 32'd0);
    check("mid_rst_over", 32'(go[1]), 32'd0);
    check("mid_rst_hiscore", 32'(hiscore[1]), 32'd0);
    check("mid_rst_state_a", 32'(dut_a.state), 32'(IDLE));

    // Score saturation at 9999
    press(1);
    frames(1, 1);
    frames(1, 999);
    check("score_999", 32'(score[1]), 32'h0999);
    frames(1, 9000);
    check("score_9999", 32'(score[1]), 32'h9999);
    frames(1, 6);
    check("score_sat", 32'(score[1]), 32'h9999);
    check("speed_sat", 32'(speed[1]), 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
